// File: rtl/cache_miss_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cache_miss_ctrl: cache miss sequencer (victim select, write-back, refill) |
// | Optional write-back path enabled by macro CACHE_WB_EN.  Rev 1.0           |
// +--------------------------------------------------------------------------+
module cache_miss_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        miss_req,
  input  logic [31:0] miss_addr,
  output logic [31:0] line_addr,
  input  logic [3:0]  victim_way,
  input  logic [3:0]  victim_dirty,
  output logic        lru_en,
  output logic [3:0]  lru_visit,
  output logic        wb_req,
  output logic [3:0]  wb_way,
  input  logic        wb_ready,
  input  logic        wb_done,
  output logic        rd_req,
  input  logic        rd_ready,
  input  logic        rd_valid,
  input  logic [31:0] rd_data,
  input  logic        rd_last,
  output logic [3:0]  way_we,
  output logic [3:0]  fill_word,
  output logic [31:0] fill_data,
  output logic        miss_done,
  output logic        busy,
  output logic        fill_err
);

`ifdef CACHE_WB_EN
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SEL     = 3'd1,
    S_WB_REQ  = 3'd2,
    S_WB_WAIT = 3'd3,
    S_RD_REQ  = 3'd4,
    S_FILL    = 3'd5,
    S_UPD     = 3'd6
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SEL     = 3'd1,
    S_RD_REQ  = 3'd4,
    S_FILL    = 3'd5,
    S_UPD     = 3'd6
  } state_t;
`endif

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_vway;
  logic [3:0]  r_cnt;
  logic [31:0] r_line_addr;
  logic        r_busy;
  logic        r_rd_req;
  logic        r_lru_en;
  logic [3:0]  r_lru_visit;
  logic        r_miss_done;
  logic        r_fill_err;
  logic        w_onehot;
  logic [3:0]  w_vway_clean;
  logic        w_beat;

  // A malformed (zero or multi-hot) victim falls back to way 0.
  assign w_onehot     = (victim_way != 4'd0) && ((victim_way & (victim_way - 4'd1)) == 4'd0);
  assign w_vway_clean = w_onehot ? victim_way : 4'b0001;
  assign w_beat       = (r_state == S_FILL) && rd_valid;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (miss_req) w_state_nxt = S_SEL;
`ifdef CACHE_WB_EN
      S_SEL:     w_state_nxt = ((victim_dirty & w_vway_clean) != 4'd0) ? S_WB_REQ : S_RD_REQ;
      S_WB_REQ:  if (wb_ready) w_state_nxt = S_WB_WAIT;
      S_WB_WAIT: if (wb_done) w_state_nxt = S_RD_REQ;
`else
      S_SEL:     w_state_nxt = S_RD_REQ;
`endif
      S_RD_REQ:  if (rd_ready) w_state_nxt = S_FILL;
      S_FILL:    if (rd_valid && (r_cnt == 4'd15)) w_state_nxt = S_UPD;
      S_UPD:     w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_vway      <= 4'd0;
      r_cnt       <= 4'd0;
      r_line_addr <= 32'd0;
      r_busy      <= 1'b0;
      r_rd_req    <= 1'b0;
      r_lru_en    <= 1'b0;
      r_lru_visit <= 4'd0;
      r_miss_done <= 1'b0;
      r_fill_err  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_busy      <= (w_state_nxt != S_IDLE);
      r_rd_req    <= (w_state_nxt == S_RD_REQ);
      r_lru_en    <= (w_state_nxt == S_UPD);
      r_miss_done <= (w_state_nxt == S_UPD);
      r_lru_visit <= (w_state_nxt == S_UPD) ? r_vway : 4'd0;
      if ((r_state == S_IDLE) && miss_req)
        r_line_addr <= {miss_addr[31:6], 6'd0};
      if (r_state == S_SEL)
        r_vway <= w_vway_clean;
      if ((r_state == S_RD_REQ) && rd_ready)
        r_cnt <= 4'd0;
      else if (w_beat)
        r_cnt <= r_cnt + 4'd1;
      // Beat counter is authoritative; an early/late rd_last only flags.
      if (w_beat && rd_last && (r_cnt != 4'd15))
        r_fill_err <= 1'b1;
    end
  end

`ifdef CACHE_WB_EN
  logic       r_wb_req;
  logic [3:0] r_wb_way;
  logic [3:0] w_vway_cur;

  assign w_vway_cur = (r_state == S_SEL) ? w_vway_clean : r_vway;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wb_req <= 1'b0;
      r_wb_way <= 4'd0;
    end else begin
      r_wb_req <= (w_state_nxt == S_WB_REQ);
      r_wb_way <= (w_state_nxt == S_WB_REQ) ? w_vway_cur : 4'd0;
    end
  end

  assign wb_req = r_wb_req;
  assign wb_way = r_wb_way;

  logic w_unused;
  assign w_unused = ^miss_addr[5:0];
`else
  assign wb_req = 1'b0;
  assign wb_way = 4'd0;

  logic w_unused;
  assign w_unused = ^{miss_addr[5:0], victim_dirty, wb_ready, wb_done};
`endif

  assign line_addr = r_line_addr;
  assign busy      = r_busy;
  assign rd_req    = r_rd_req;
  assign lru_en    = r_lru_en;
  assign lru_visit = r_lru_visit;
  assign miss_done = r_miss_done;
  assign fill_err  = r_fill_err;
  assign way_we    = w_beat ? r_vway : 4'd0;
  assign fill_word = w_beat ? r_cnt : 4'd0;
  assign fill_data = w_beat ? rd_data : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_cache_miss_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_cache_miss_ctrl: self-checking bench for cache_miss_ctrl               |
// | Honours CACHE_WB_EN when defined for the build.  Rev 1.0                  |
// +--------------------------------------------------------------------------+
module tb_cache_miss_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        miss_req = 1'b0;
  logic [31:0] miss_addr = 32'd0;
  logic [31:0] line_addr;
  logic [3:0]  victim_way = 4'd0;
  logic [3:0]  victim_dirty = 4'd0;
  logic        lru_en;
  logic [3:0]  lru_visit;
  logic        wb_req;
  logic [3:0]  wb_way;
  logic        wb_ready = 1'b0;
  logic        wb_done = 1'b0;
  logic        rd_req;
  logic        rd_ready = 1'b0;
  logic        rd_valid = 1'b0;
  logic [31:0] rd_data = 32'd0;
  logic        rd_last = 1'b0;
  logic [3:0]  way_we;
  logic [3:0]  fill_word;
  logic [31:0] fill_data;
  logic        miss_done;
  logic        busy;
  logic        fill_err;

  cache_miss_ctrl u_dut (
    .clk(clk), .rst(rst), .miss_req(miss_req), .miss_addr(miss_addr),
    .line_addr(line_addr), .victim_way(victim_way), .victim_dirty(victim_dirty),
    .lru_en(lru_en), .lru_visit(lru_visit), .wb_req(wb_req), .wb_way(wb_way),
    .wb_ready(wb_ready), .wb_done(wb_done), .rd_req(rd_req), .rd_ready(rd_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last), .way_we(way_we),
    .fill_word(fill_word), .fill_data(fill_data), .miss_done(miss_done),
    .busy(busy), .fill_err(fill_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  bit err_model = 1'b0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [3:0] exp_way(input logic [3:0] v);
    return ($countones(v) == 1) ? v : 4'b0001;
  endfunction

  // gap_mode: 0 beats every cycle, 1 alternate cycles, 2 random.
  // last_beat: beat index carrying rd_last (-1 none). abort_beat: reset there (-1 none).
  task automatic run_miss(input logic [31:0] addr, input logic [3:0] vic, input logic [3:0] dirty,
                          input int rd_dly, input int gap_mode, input int last_beat,
                          input int wb_rdy_dly, input int wb_done_dly, input int abort_beat);
    logic [3:0] expv = exp_way(vic);
    bit exp_wb;
    bit fin = 1'b0, aborted = 1'b0, wb_acc = 1'b0, wb_fin = 1'b0, rd_acc = 1'b0;
    int wb_cnt = 0, wait_cnt = 0, done_cyc = -1, rd_first = -1, rd_cnt = 0;
    int beats = 0, fill_cyc = 0, done_cnt = 0;
`ifdef CACHE_WB_EN
    exp_wb = ((dirty & expv) != 4'd0);
`else
    exp_wb = 1'b0;
`endif
    for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
      @(posedge clk); #1;
      miss_req = (cyc == 0);
      miss_addr = addr; victim_way = vic; victim_dirty = dirty;
      wb_ready = 1'b0; wb_done = 1'b0; rd_ready = 1'b0;
      rd_valid = 1'b0; rd_last = 1'b0; rd_data = 32'd0;
      if (wb_req) begin
        wb_cnt++;
        if (wb_cnt > wb_rdy_dly) begin
          wb_ready = 1'b1; wb_done = 1'b1; wb_acc = 1'b1; wait_cnt = 0;
        end
      end else if (wb_acc && !wb_fin) begin
        wait_cnt++;
        if (wait_cnt == wb_done_dly) begin wb_done = 1'b1; wb_fin = 1'b1; done_cyc = cyc; end
      end
      if (rd_req) begin
        if (rd_first < 0) rd_first = cyc;
        rd_cnt++;
        if (rd_cnt > rd_dly) begin rd_ready = 1'b1; rd_acc = 1'b1; end
      end else if (rd_acc && beats < 16) begin
        case (gap_mode)
          0:       rd_valid = 1'b1;
          1:       rd_valid = (fill_cyc % 2 == 0);
          default: rd_valid = 1'($urandom_range(0, 1));
        endcase
        fill_cyc++;
        if (rd_valid) begin
          rd_data = $urandom;
          rd_last = (beats == last_beat);
          if (rd_last && beats != 15) err_model = 1'b1;
        end
      end
      if (rd_valid && beats == abort_beat) begin
        rst = 1'b1;
        #1;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_way_we", 32'(way_we), 0);
        fin = 1'b1; aborted = 1'b1;
      end else begin
        #3;
        if (cyc == 0) chk("idle_busy", 32'(busy), 0);
        if (cyc == 1) begin
          chk("sel_busy", 32'(busy), 1);
          chk("line_addr", line_addr, addr & ~32'h3f);
        end
        if (wb_req) chk("wb_way", 32'(wb_way), 32'(expv));
        if (rd_valid) begin
          chk("beat_way_we", 32'(way_we), 32'(expv));
          chk("beat_fill_word", 32'(fill_word), beats);
          chk("beat_fill_data", fill_data, rd_data);
          beats++;
        end else begin
          chk("gap_way_we", 32'(way_we), 0);
        end
        if (lru_en && !miss_done) chk("lru_en_without_done", 1, 0);
        if (miss_done) begin
          done_cnt++;
          chk("upd_lru_en", 32'(lru_en), 1);
          chk("upd_lru_visit", 32'(lru_visit), 32'(expv));
          chk("done_after_beats", beats, 16);
          fin = 1'b1;
        end
      end
    end
    if (!fin) chk("timeout", 0, 1);
    if (aborted) begin
      @(posedge clk); #1;
      chk("rst_no_done", 32'(miss_done), 0);
      chk("rst_no_lru_en", 32'(lru_en), 0);
      chk("rst_fill_err", 32'(fill_err), 0);
      err_model = 1'b0;
      rst = 1'b0;
      rd_valid = 1'b0; rd_last = 1'b0;
    end else begin
      chk("done_count", done_cnt, 1);
      chk("wb_req_cycles", wb_cnt, exp_wb ? wb_rdy_dly + 1 : 0);
      chk("rd_req_first_cycle", rd_first, exp_wb ? done_cyc + 1 : 2);
      chk("fill_err", 32'(fill_err), 32'(err_model));
    end
  endtask

  initial begin
    #1 rst = 1'b1;
    #2;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rd_req", 32'(rd_req), 0);
    chk("rst_wb_req", 32'(wb_req), 0);
    chk("rst_miss_done", 32'(miss_done), 0);
    chk("rst_lru_en", 32'(lru_en), 0);
    chk("rst_way_we", 32'(way_we), 0);
    chk("rst_fill_err", 32'(fill_err), 0);
    chk("rst_line_addr", line_addr, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    run_miss(32'h1234_5678, 4'b0100, 4'b0000, 0, 0, 15, 0, 1, -1);
    run_miss(32'hABCD_EF40, 4'b1000, 4'b1000, 0, 0, 15, 3, 5, -1);
    run_miss(32'h0000_1FFF, 4'b0010, 4'b0001, 1, 1, 15, 0, 1, -1);
    run_miss(32'h8000_0040, 4'b0001, 4'b0000, 0, 0, 7, 0, 1, -1);
    run_miss(32'h5555_AAAA, 4'b1000, 4'b0000, 2, 2, 15, 0, 1, -1);
    run_miss(32'hC0DE_0080, 4'b0110, 4'b0001, 0, 0, 15, 1, 2, -1);
    run_miss(32'h7777_7777, 4'b0100, 4'b0000, 0, 0, 15, 0, 1, 9);
    run_miss(32'h2468_ACE0, 4'b0100, 4'b0000, 0, 0, 15, 0, 1, -1);
    for (int i = 0; i < 10; i++)
      run_miss($urandom, 4'($urandom), 4'($urandom), int'($urandom_range(0, 3)), 2,
               ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : 15,
               int'($urandom_range(0, 3)), int'($urandom_range(1, 4)), -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/cache_miss_ctrl.md
CACHE_MISS_CTRL -- requirements
Module: cache_miss_ctrl

Interface
REQ-001 clk  in  1  single clock; all state updates on posedge.
REQ-002 rst  in  1  asynchronous, active-high reset.
REQ-003 miss_req  in  1  level; a cache miss is pending.
REQ-004 miss_addr  in  32  miss address, sampled in IDLE.
REQ-005 line_addr  out  32  latched miss address with bits [5:0] cleared; drives the LRU selector's addr_rbuf.
REQ-006 victim_way  in  4  one-hot victim from the LRU selector for line_addr[11:6].
REQ-007 victim_dirty  in  4  per-way dirty bits of the indexed set.
REQ-008 lru_en  out  1  LRU update strobe.
REQ-009 lru_visit  out  4  one-hot way to promote.
REQ-010 wb_req  out  1  write-back request; wb_way is 4 bits out; wb_ready in 1 accepts; wb_done in 1 completes.
REQ-011 rd_req  out  1  refill read request; rd_ready in 1 accepts; rd_valid in 1 marks a beat; rd_data in 32 carries it; rd_last in 1 flags the final beat.
REQ-012 way_we  out  4  one-hot data-array write enable.
REQ-013 fill_word  out  4  word index within the line.
REQ-014 fill_data  out  32  write data.
REQ-015 miss_done  out  1  one-cycle completion pulse.
REQ-016 busy  out  1  high in any state other than IDLE.
REQ-017 fill_err  out  1  sticky flag, cleared only by reset.

Function
REQ-018 FSM states SHALL be IDLE, SEL, WB_REQ, WB_WAIT, RD_REQ, FILL and UPD.
REQ-019 IDLE: when miss_req=1, SHALL latch miss_addr into line_addr and go to SEL.
REQ-020 SEL: SHALL stay exactly 1 cycle and latch victim_way into vway_q; a victim that is not one-hot SHALL be latched as 4'b0001.
REQ-021 SEL: SHALL go to WB_REQ if victim_dirty is set for vway_q (CACHE_WB_EN only), otherwise to RD_REQ.
REQ-022 WB_REQ: wb_req=1 and wb_way=vway_q, held until wb_ready=1 is sampled, then go to WB_WAIT.
REQ-023 WB_WAIT: SHALL wait for wb_done=1, then go to RD_REQ; wb_done arriving in the same cycle as wb_ready SHALL be ignored.
REQ-024 RD_REQ: rd_req=1 until rd_ready=1, then go to FILL with the 4-bit beat counter at 0.
REQ-025 FILL: on each rd_valid, SHALL drive way_we=vway_q, fill_word=counter and fill_data=rd_data in the same cycle (combinational), then increment the counter; way_we=0 without rd_valid.
REQ-026 FILL: the beat with counter=15 SHALL be the last; the counter wraps to 0 and the FSM goes to UPD; the counter is authoritative, not rd_last.
REQ-027 Any rd_last that does not coincide with counter=15 SHALL set fill_err; fill_err has no effect on sequencing.
REQ-028 UPD: 1 cycle with lru_en=1, lru_visit=vway_q and miss_done=1, then go to IDLE.
REQ-029 miss_req still high in the IDLE cycle after UPD SHALL start a new miss; minimum miss-to-miss spacing is 1 idle cycle.
REQ-030 Clean-miss latency: miss_req to first rd_req = 2 cycles (IDLE, SEL).
REQ-031 Outputs not asserted by the current state SHALL be 0.

Reset
REQ-032 rst=1 SHALL immediately force IDLE, counter=0, vway_q=0, line_addr=0 and fill_err=0, with every output at 0.
REQ-033 A reset mid-operation SHALL abandon any write-back or refill without a miss_done or lru_en pulse.

Configuration
REQ-034 With macro CACHE_WB_EN defined, dirty victims SHALL go through WB_REQ/WB_WAIT.
REQ-035 With CACHE_WB_EN undefined, the WB states SHALL be removed, victim_dirty, wb_ready and wb_done SHALL be ignored, and wb_req/wb_way SHALL be tied to 0.

Verification
REQ-036 Clean miss, victim 4'b0100, rd_ready immediate, 16 back-to-back beats -> way_we=4'b0100 on 16 cycles, fill_word 0..15, lru_visit=4'b0100, one miss_done.
REQ-037 Dirty miss, victim 4'b1000, wb_ready after 3 cycles, wb_done after 5 more (CACHE_WB_EN) -> wb_way=4'b1000, rd_req only after wb_done; undefined macro -> no wb_req.
REQ-038 Refill with rd_valid gaps (beats on alternate cycles) -> counter holds in gaps, way_we=0 in gaps, miss_done after the 16th beat.
REQ-039 rd_last on beat 7 -> fill_err=1 and the fill still completes after 16 beats; fill_err stays 1 until rst.
REQ-040 rst pulse at beat 9 -> busy=0 and way_we=0 immediately, no miss_done; next miss restarts at fill_word=0.
REQ-041 victim_way=4'b0110 -> vway_q=4'b0001, writes go to way 0.
